// File: rtl/kd_internal_node_tree_pkg.sv
// Shared constants and helpers for the kd-tree internal-node traversal pipeline.
// Node word: [10:0] split dimension, [21:11] signed median.
package kd_internal_node_tree_pkg;

    localparam int COMP_W       = 11;
    localparam int NUM_DIMS     = 5;
    localparam int DEPTH        = 6;
    localparam int NUM_INTERNAL = (1 << DEPTH) - 1;
    localparam int PTR_W        = 6;
    localparam int NODE_W       = 2 * COMP_W;
    localparam int PATCH_W      = NUM_DIMS * COMP_W;
    localparam int DIM_LSB      = 0;
    localparam int DIM_MSB      = COMP_W - 1;
    localparam int MED_LSB      = COMP_W;
    localparam int MED_MSB      = 2 * COMP_W - 1;

    // Out-of-range dimensions fall back to component 0.
    function automatic logic signed [COMP_W-1:0] sel_comp(
        input logic [PATCH_W-1:0] patch,
        input logic [COMP_W-1:0]  dim
    );
        logic signed [COMP_W-1:0] comp;
        case (dim)
            11'd1:   comp = patch[2*COMP_W-1:1*COMP_W];
            11'd2:   comp = patch[3*COMP_W-1:2*COMP_W];
            11'd3:   comp = patch[4*COMP_W-1:3*COMP_W];
            11'd4:   comp = patch[5*COMP_W-1:4*COMP_W];
            default: comp = patch[1*COMP_W-1:0];
        endcase
        return comp;
    endfunction

endpackage

// File: rtl/kd_internal_node_tree_if.sv
// Load-port and query/result bundle for the kd-tree traversal block.
// The master side drives node words and queries; the slave returns the leaf index.
interface kd_internal_node_tree_if #(
    parameter int INTERNAL_WIDTH = 22,
    parameter int PATCH_WIDTH    = 55,
    parameter int ADDRESS_WIDTH  = 8
);
    logic                      fsm_enable;
    logic                      sender_enable;
    logic [INTERNAL_WIDTH-1:0] sender_data;
    logic [PATCH_WIDTH-1:0]    patch_in;
    logic [ADDRESS_WIDTH-1:0]  leaf_index;

    modport master (
        output fsm_enable, sender_enable, sender_data, patch_in,
        input  leaf_index
    );

    modport slave (
        input  fsm_enable, sender_enable, sender_data, patch_in,
        output leaf_index
    );
endinterface

// File: rtl/kd_internal_node_tree_level.sv
// One tree level: node store for this level, split compare, append one path bit.
// Latency 1 cycle; no backpressure, accepts a query every cycle.
module internal_node_level
    import kd_internal_node_tree_pkg::*;
#(
    parameter int LEVEL = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_wr_en,
    input  logic [PTR_W-1:0]   i_wr_ptr,
    input  logic [NODE_W-1:0]  i_wr_dat,
    input  logic [PATCH_W-1:0] i_patch,
    input  logic [DEPTH-1:0]   i_path,
    output logic [PATCH_W-1:0] o_patch,
    output logic [DEPTH-1:0]   o_path
);
    localparam int NODES = 1 << LEVEL;
    localparam int BASE  = NODES - 1;
    localparam int SLOTS = (LEVEL == 0) ? 2 : NODES;
    localparam int IDX_W = (LEVEL == 0) ? 1 : LEVEL;

    logic [NODE_W-1:0] r_nodes [SLOTS];

    logic [PTR_W-1:0]         w_wr_off;
    logic                     w_wr_hit;
    logic [IDX_W-1:0]         w_idx;
    logic [NODE_W-1:0]        w_node;
    logic signed [COMP_W-1:0] w_comp;
    logic signed [COMP_W-1:0] w_med;
    logic                     w_right;
    logic                     w_unused;

    // Pointers below BASE wrap to large offsets, so one compare covers both bounds.
    assign w_wr_off = i_wr_ptr - PTR_W'(BASE);
    assign w_wr_hit = i_wr_en && (w_wr_off < PTR_W'(NODES));

    assign w_idx    = i_path[IDX_W-1:0];
    assign w_node   = r_nodes[w_idx];
    assign w_med    = w_node[MED_MSB:MED_LSB];
    assign w_comp   = sel_comp(i_patch, w_node[DIM_MSB:DIM_LSB]);
    assign w_right  = (w_comp >= w_med);
    assign w_unused = i_path[DEPTH-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < SLOTS; i++) begin
                r_nodes[i] <= '0;
            end
            o_patch <= '0;
            o_path  <= '0;
        end else begin
            if (w_wr_hit) begin
                r_nodes[w_wr_off[IDX_W-1:0]] <= i_wr_dat;
            end
            o_patch <= i_patch;
            o_path  <= {i_path[DEPTH-2:0], w_right};
        end
    end

endmodule

// File: rtl/kd_internal_node_tree.sv
// Loads a 63-node kd-tree in level order and classifies one query patch per cycle to a leaf.
// Latency 6 cycles from patch_in sampled to leaf_index; no backpressure.
module kd_internal_node_tree
    import kd_internal_node_tree_pkg::*;
#(
    parameter int INTERNAL_WIDTH = 22,
    parameter int PATCH_WIDTH    = 55,
    parameter int ADDRESS_WIDTH  = 8
) (
    input  logic clk,
    input  logic rst,
    kd_internal_node_tree_if.slave bus
);
    logic [PTR_W-1:0]       r_wr_ptr;
    logic [PATCH_WIDTH-1:0] r_patch;
    logic                   w_wr_en;
    logic [DEPTH-1:0]       w_path  [DEPTH+1];
    logic [PATCH_W-1:0]     w_patch [DEPTH+1];

    // Saturates at the last node; only reset re-opens the load window.
    assign w_wr_en = bus.fsm_enable && bus.sender_enable &&
                     (r_wr_ptr != PTR_W'(NUM_INTERNAL));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_patch  <= '0;
        end else begin
            if (w_wr_en) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            r_patch <= bus.patch_in;
        end
    end

    assign w_path[0]  = '0;
    assign w_patch[0] = r_patch;

    for (genvar l = 0; l < DEPTH; l++) begin : g_level
        internal_node_level #(.LEVEL(l)) u_level (
            .clk      (clk),
            .rst      (rst),
            .i_wr_en  (w_wr_en),
            .i_wr_ptr (r_wr_ptr),
            .i_wr_dat (bus.sender_data),
            .i_patch  (w_patch[l]),
            .i_path   (w_path[l]),
            .o_patch  (w_patch[l+1]),
            .o_path   (w_path[l+1])
        );
    end

    // Final path bits are the leaf offset from node 63.
    assign bus.leaf_index = {{(ADDRESS_WIDTH-DEPTH){1'b0}}, w_path[DEPTH]};

endmodule

// File: tb/tb_kd_internal_node_tree.sv
// Table-driven bench with a latency-aligned scoreboard and a reference tree model.
module tb_kd_internal_node_tree;

    localparam int LAT = 7;   // negedges between driving patch_in and seeing its leaf

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    kd_internal_node_tree_if #(.INTERNAL_WIDTH(22), .PATCH_WIDTH(55), .ADDRESS_WIDTH(8)) bus ();

    kd_internal_node_tree #(.INTERNAL_WIDTH(22), .PATCH_WIDTH(55), .ADDRESS_WIDTH(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        bit vld;
        int exp;
        int tag;
    } sb_t;

    typedef struct {
        int c0, c1, c2, c3, c4;
        int exp;
    } vec_t;

    sb_t         sbq[$];
    int          n_vec = 0;
    int          n_err = 0;
    logic [21:0] m_node [63];
    int          m_ptr;

    function automatic logic [54:0] mk_patch(int c0, int c1, int c2, int c3, int c4);
        logic [10:0] a0, a1, a2, a3, a4;
        a0 = 11'(c0); a1 = 11'(c1); a2 = 11'(c2); a3 = 11'(c3); a4 = 11'(c4);
        return {a4, a3, a2, a1, a0};
    endfunction

    function automatic int model_leaf(logic [54:0] p);
        int n = 0;
        int di;
        logic [10:0] d;
        logic signed [10:0] c, m;
        for (int l = 0; l < 6; l++) begin
            d  = m_node[n][10:0];
            m  = m_node[n][21:11];
            di = (d > 11'd4) ? 0 : int'(d);
            c  = p[11*di +: 11];
            n  = (c >= m) ? 2*n + 2 : 2*n + 1;
        end
        return n - 63;
    endfunction

    task automatic tick(input logic fsm, input logic snd, input logic [21:0] dat,
                        input logic [54:0] patch, input bit vld, input int exp, input int tag);
        sb_t e;
        @(negedge clk);
        if (sbq.size() == LAT) begin
            e = sbq.pop_front();
            if (e.vld) begin
                n_vec++;
                if (int'(bus.leaf_index) != e.exp) begin
                    n_err++;
                    $display("FAIL leaf_vec%0d: leaf_index=%0d expected %0d", e.tag, bus.leaf_index, e.exp);
                end
            end
        end
        bus.fsm_enable    = fsm;
        bus.sender_enable = snd;
        bus.sender_data   = dat;
        bus.patch_in      = patch;
        sbq.push_back('{vld, exp, tag});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 22'h0, mk_patch(-1, -1, -1, -1, -1), 1'b0, 0, 0);
    endtask

    task automatic wr(input logic fsm, input logic snd, input int dim, input int med);
        logic [10:0] d, m;
        d = 11'(dim);
        m = 11'(med);
        tick(fsm, snd, {m, d}, mk_patch(-1, -1, -1, -1, -1), 1'b0, 0, 0);
        if (fsm && snd && m_ptr < 63) begin
            m_node[m_ptr] = {m, d};
            m_ptr++;
        end
    endtask

    task automatic query(input logic [54:0] p, input int exp, input int tag);
        tick(1'b0, 1'b0, 22'h0, p, 1'b1, exp, tag);
    endtask

    task automatic do_reset(input int tag);
        @(negedge clk);
        rst = 1'b1;
        bus.fsm_enable    = 1'b0;
        bus.sender_enable = 1'b0;
        sbq.delete();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        m_ptr = 0;
        for (int i = 0; i < 63; i++) m_node[i] = '0;
        n_vec++;
        if (bus.leaf_index != 8'd0) begin
            n_err++;
            $display("FAIL rst_leaf%0d: leaf_index=%0d expected 0", tag, bus.leaf_index);
        end
    endtask

    task automatic apply(input vec_t v[4], input int tag0);
        for (int i = 0; i < 4; i++) query(mk_patch(v[i].c0, v[i].c1, v[i].c2, v[i].c3, v[i].c4), v[i].exp, tag0 + i);
        idle(LAT + 1);
    endtask

    vec_t va[4];
    vec_t vb[4];

    initial begin
        va[0] = '{-1, 0, 0, 0, 0, 0};
        va[1] = '{5, 0, 0, 0, 0, 63};
        va[2] = '{0, -1, -1, -1, -1, 63};
        va[3] = '{-1, 500, 500, 500, 500, 0};
        vb[0] = '{-1024, -1024, -1024, -1024, 101, 63};
        vb[1] = '{-1024, -1024, -1024, -1024, 99, 0};
        vb[2] = '{1000, 1000, 1000, 1000, 100, 63};
        vb[3] = '{1000, 1000, 1000, 1000, -1024, 0};

        bus.fsm_enable    = 1'b0;
        bus.sender_enable = 1'b0;
        bus.sender_data   = '0;
        bus.patch_in      = '0;
        do_reset(0);

        // Gated writes must not advance the load pointer.
        wr(1'b0, 1'b1, 0, 500);
        wr(1'b1, 1'b0, 0, 500);
        for (int i = 0; i < 63; i++) wr(1'b1, 1'b1, 0, 0);
        idle(2);
        apply(va, 100);

        // 64th word must neither wrap nor overwrite node 0.
        wr(1'b1, 1'b1, 0, -1024);
        idle(2);
        apply(va, 200);

        for (int i = 0; i < 6; i++) query(mk_patch((i % 2 == 0) ? -1 : 5, 0, 0, 0, 0), (i % 2 == 0) ? 0 : 63, 300 + i);
        idle(LAT + 1);

        do_reset(1);
        for (int i = 0; i < 63; i++) wr(1'b1, 1'b1, 4, 100);
        idle(2);
        apply(vb, 400);

        do_reset(2);
        for (int i = 0; i < 10; i++) wr(1'b1, 1'b1, 0, 1000);
        do_reset(3);
        wr(1'b0, 1'b1, 0, 1000);
        for (int n = 0; n < 63; n++) wr(1'b1, 1'b1, n % 7, -100 + ((n * 13) % 50));
        idle(2);
        query(mk_patch(79, -88, -1, -26, 251), 63, 500);
        for (int i = 0; i < 10; i++) begin
            logic [54:0] p;
            p = mk_patch(int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 255)) - 128,
                         int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 255)) - 128,
                         int'($urandom_range(0, 255)) - 128);
            query(p, model_leaf(p), 501 + i);
        end
        idle(LAT + 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/kd_internal_node_tree.md
KD_INTERNAL_NODE_TREE -- requirements
Module: kd_internal_node_tree

Interface
REQ-001 SHALL have parameter INTERNAL_WIDTH, default 22, width of one packed internal-node word.
REQ-002 SHALL have parameter PATCH_WIDTH, default 55, width of a query patch (5 signed 11-bit components).
REQ-003 SHALL have parameter ADDRESS_WIDTH, default 8, width of leaf_index.
REQ-004 SHALL have port clk  input  1  sole clock; all logic on its rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port fsm_enable  input  1  load-phase enable; node writes accepted only while high.
REQ-007 SHALL have port sender_enable  input  1  one-cycle strobe: sender_data holds a valid node word.
REQ-008 SHALL have port sender_data  input  INTERNAL_WIDTH  node word: [10:0] split dimension (unsigned, 0..4), [21:11] median (signed 11-bit).
REQ-009 SHALL have port patch_in  input  PATCH_WIDTH  query; component d (0..4) is signed, at bits [11d+10:11d].
REQ-010 SHALL have port leaf_index  output  ADDRESS_WIDTH  leaf reached by the query, zero-extended.

Function
REQ-011 SHALL store a complete binary tree of depth 6: 63 internal nodes, 64 leaves, in level order (node n has children 2n+1, 2n+2).
REQ-012 SHALL, on a cycle with fsm_enable=1 and sender_enable=1, write sender_data into node[wr_ptr] and increment wr_ptr by 1.
REQ-013 SHALL ignore writes when fsm_enable=0 or sender_enable=0; wr_ptr holds.
REQ-014 SHALL ignore writes once 63 nodes are loaded (wr_ptr=63 saturates, no wrap, no overwrite) until rst.
REQ-015 SHALL traverse with a 6-stage pipeline, one tree level per stage; stage L reads the level-L node selected by the path so far.
REQ-016 SHALL, at each node, compare patch component [dim] with median as signed 11-bit; component < median goes left, component >= median (equality included) goes right.
REQ-017 SHALL treat a dim field > 4 as dim 0.
REQ-018 SHALL output leaf_index = final node position minus 63, range 0..63 (all-left = 0, all-right = 63).
REQ-019 SHALL register leaf_index 6 cycles after patch_in is sampled; fully pipelined, a new patch accepted every cycle.
REQ-020 SHALL traverse continuously regardless of fsm_enable; a node written in cycle t is used by any stage reading it in cycle t+1 or later.

Reset
REQ-021 SHALL on rst=1 at a clock edge clear wr_ptr to 0, all node words to 0, all pipeline registers and leaf_index to 0.
REQ-022 SHALL let rst asserted mid-load abandon the load; the next accepted word after rst is written to node 0.
REQ-023 SHALL give rst priority over a coincident write.

Structure
REQ-024 SHALL place shared constants in a package: component width 11, dimension count 5, tree depth 6, internal-node count 63, node-word field positions.
REQ-025 SHALL implement one per-level stage sub-module, internal_node_level (level node store + compare + path-bit append), instantiated 6 times.

Verification
REQ-026 SHALL cover: load 63 words dim=0 median=0; patch comp0=-1 -> leaf_index 0; comp0=5 -> leaf_index 63, each exactly 6 cycles after patch_in.
REQ-027 SHALL cover equality: all medians 0, comp0=0 -> leaf_index 63.
REQ-028 SHALL cover dimension select: all nodes dim=4 median=100; patch comp4=101, comp0..3=-1024 -> 63; comp4=99 -> 0.
REQ-029 SHALL cover overflow: 64th word (dim 0, median -1024) with fsm_enable=1 ignored; node 0..62 contents and results unchanged.
REQ-030 SHALL cover gating and reset: words with fsm_enable=0 ignored; rst after 10 words, reload 63 words, then patch [comp0..4]=[79,-88,-1,-26,251] against the golden tree yields expected leaf 63.
REQ-031 SHALL cover throughput: 6 back-to-back alternating patches (comp0=-1/+5) with medians 0 -> leaf_index 0,63,0,63,0,63 on consecutive cycles.
